mul_issue_ctrl: RTL and testbench
=================================

// Module: mul_issue_ctrl
// PURPOSE
//   Issue/hazard controller for the fixed-latency pipelined multiplier in EX.
//   Tracks every in-flight multiply (valid + rd) in an age-indexed shift register.
//   Stalls the issuing instruction on RAW, WAW and writeback-port conflicts.
//   Announces each multiply result on the shared register-file write port.
//   Sits between decode/issue and the multiplier + writeback mux; the multiplier holds no state of its own.
// PARAMETERS
//   MUL_LATENCY  5  cycles from multiply accept to its writeback cycle (>=2)
//   WB_DELAY     2  cycles from non-mul accept to its writeback cycle (1 <= WB_DELAY < MUL_LATENCY)
//   REG_ADDR_W   5  architectural register index width
// PORTS
//   clk              in   1           clock, rising edge
//   rst              in   1           asynchronous reset, active-low
//   issue_valid      in   1           instruction presented for issue this cycle
//   issue_is_mul     in   1           instruction is MUL-class (goes to the multiplier)
//   issue_writes_rd  in   1           instruction writes rd
//   issue_rd         in   REG_ADDR_W  destination register
//   issue_uses_rs1   in   1           rs1 is read
//   issue_rs1        in   REG_ADDR_W  source register 1
//   issue_uses_rs2   in   1           rs2 is read
//   issue_rs2        in   REG_ADDR_W  source register 2
//   flush            in   1           squash the instruction at issue this cycle
//   stall            out  1           hold issue stage (combinational)
//   mul_accept       out  1           multiplier captures operands this cycle (combinational)
//   mul_wb_valid     out  1           multiplier result is written back this cycle (registered)
//   mul_wb_rd        out  REG_ADDR_W  destination of that result (registered)
//   inflight_cnt     out  $clog2(MUL_LATENCY+1)  number of multiplies in flight (registered)
//   busy             out  1           inflight_cnt != 0
// BEHAVIOUR
//   - Reset (rst=0, async): clear all tracking slots.
//     - mul_wb_valid=0, mul_wb_rd=0, inflight_cnt=0, busy=0.
//     - stall=0 and mul_accept=0 while rst is low.
//   - Slots age 1..MUL_LATENCY; each holds valid+rd and shifts one age per cycle.
//     - An accepted mul enters age 1 on the next edge.
//     - mul_wb_valid/mul_wb_rd reflect the age-MUL_LATENCY slot.
//     - Accept at cycle T gives writeback at cycle T+MUL_LATENCY.
//   - Hazard match: a valid slot at any age 1..MUL_LATENCY whose rd equals the compared register.
//     - rd==0 never matches.
//   - stall = issue_valid & !flush & (raw | waw | wbc):
//     - raw: (uses_rs1 & match(rs1)) | (uses_rs2 & match(rs2)).
//     - waw: !is_mul & writes_rd & match(rd).
//       - Mul-after-mul to the same rd is allowed (in order).
//     - wbc: !is_mul & writes_rd & valid slot at age MUL_LATENCY-WB_DELAY.
//       - Its writeback would collide with the mul result.
//   - mul_accept = issue_valid & issue_is_mul & !stall & !flush.
//   - flush only squashes the current issue; accepted multiplies always complete and write back.
//   - Mul accept and mul retire in the same cycle: inflight_cnt unchanged.
//     - inflight_cnt = +1 on accept only, -1 on retire only.
//   - A stalled RAW consumer of a mul issues the cycle after that mul's writeback cycle.
//     - No forwarding from the multiplier.
//   - Mul with rd=0: still tracked and still produces mul_wb_valid; never causes a hazard.
//   - Reset mid-operation drops all in-flight results; no mul_wb_valid after release.
// TESTING
//   1. Independent muls rd=1..5 issued cycles 0..4 -> stall=0 throughout.
//      mul_wb_valid cycles 5..9 with rd 1..5; inflight_cnt=5 at cycle 5, 0 at cycle 10.
//   2. Mul rd=3 cycle 0, then add rs1=3 -> stall=1 cycles 1..5; add issues cycle 6.
//   3. Mul rd=4 cycle 0, ALU op writing rd=7 presented cycle 3 (age 3) -> stall=1 cycle 3, issues cycle 4.
//      No two writebacks share a cycle.
//   4. Mul rd=0 cycle 0, add rs1=0 rs2=0 rd=0 cycle 1 -> stall=0; mul_wb_valid=1, rd=0 at cycle 5.
//   5. Muls cycles 0..2, rst low at cycle 3 for 1 cycle -> all outputs 0 immediately.
//      No mul_wb_valid afterwards; inflight_cnt=0.
//   6. Mul cycle 0; cycle 1 mul with flush=1 -> mul_accept=0 at cycle 1.
//      First mul still writes back at cycle 5; inflight_cnt peaks at 1.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue/hazard control for the fixed-latency pipelined multiplier.
// The multiplier has no state of its own. This block keeps one tracking slot per
// pipeline age, and each slot holds a valid bit and a destination register. The
// slots are used to detect RAW, WAW and writeback-port hazards at issue. The oldest
// slot drives the multiplier result announcement on the shared register write port.

module mul_issue_ctrl #(
    parameter int MUL_LATENCY = 5,
    parameter int WB_DELAY    = 2,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               issue_valid,
    input  logic                               issue_is_mul,
    input  logic                               issue_writes_rd,
    input  logic [REG_ADDR_W-1:0]              issue_rd,
    input  logic                               issue_uses_rs1,
    input  logic [REG_ADDR_W-1:0]              issue_rs1,
    input  logic                               issue_uses_rs2,
    input  logic [REG_ADDR_W-1:0]              issue_rs2,
    input  logic                               flush,
    output logic                               stall,
    output logic                               mul_accept,
    output logic                               mul_wb_valid,
    output logic [REG_ADDR_W-1:0]              mul_wb_rd,
    output logic [$clog2(MUL_LATENCY+1)-1:0]   inflight_cnt,
    output logic                               busy
);

    localparam int CNT_W   = $clog2(MUL_LATENCY+1);
    // A non-mul accepted now writes back in the same cycle as the mul at this age.
    localparam int WBC_AGE = MUL_LATENCY - WB_DELAY;

    logic [MUL_LATENCY:1]  slot_v;
    logic [REG_ADDR_W-1:0] slot_rd [1:MUL_LATENCY];

    logic raw_hit;
    logic rd_hit;
    logic wbc_hit;
    logic retire;

    // Compare the issuing registers against every in-flight destination; r0 never matches.
    always_comb begin
        raw_hit = 1'b0;
        rd_hit  = 1'b0;
        for (int a = 1; a <= MUL_LATENCY; a++) begin
            if (slot_v[a] && (slot_rd[a] != '0)) begin
                if (issue_uses_rs1 && (slot_rd[a] == issue_rs1)) raw_hit = 1'b1;
                if (issue_uses_rs2 && (slot_rd[a] == issue_rs2)) raw_hit = 1'b1;
                if (slot_rd[a] == issue_rd)                      rd_hit  = 1'b1;
            end
        end
    end

    assign wbc_hit = slot_v[WBC_AGE];
    assign retire  = slot_v[MUL_LATENCY];

    // Issue decision. Multiplies may overwrite an in-flight mul's rd because they
    // retire in order. A flushed instruction never stalls and is never accepted.
    always_comb begin
        stall      = 1'b0;
        mul_accept = 1'b0;
        if (rst && issue_valid && !flush) begin
            stall = raw_hit |
                    (!issue_is_mul & issue_writes_rd & (rd_hit | wbc_hit));
            mul_accept = issue_is_mul & !stall;
        end
    end

    // The age shift register. A newly accepted mul enters age 1, and every slot ages by one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_v <= '0;
            for (int a = 1; a <= MUL_LATENCY; a++) slot_rd[a] <= '0;
        end else begin
            slot_v     <= {slot_v[MUL_LATENCY-1:1], mul_accept};
            slot_rd[1] <= mul_accept ? issue_rd : '0;
            for (int a = 2; a <= MUL_LATENCY; a++) slot_rd[a] <= slot_rd[a-1];
        end
    end

    // Count in-flight multiplies. An accept and a retire in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_cnt <= '0;
        end else if (mul_accept && !retire) begin
            inflight_cnt <= inflight_cnt + CNT_W'(1);
        end else if (!mul_accept && retire) begin
            inflight_cnt <= inflight_cnt - CNT_W'(1);
        end
    end

    assign mul_wb_valid = slot_v[MUL_LATENCY];
    assign mul_wb_rd    = slot_rd[MUL_LATENCY];
    assign busy         = (inflight_cnt != '0);

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Testbench for mul_issue_ctrl. The reference model keeps a list of accepted
// multiplies, and it derives each multiply's age from the current cycle number.
// A monitor checks the writebacks against a scoreboard queue.

module tb_mul_issue_ctrl;

    localparam int L  = 5;
    localparam int WB = 2;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          issue_valid = 1'b0, issue_is_mul = 1'b0, issue_writes_rd = 1'b0;
    logic [AW-1:0] issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
    logic          issue_uses_rs1 = 1'b0, issue_uses_rs2 = 1'b0, flush = 1'b0;
    logic          stall, mul_accept, mul_wb_valid, busy;
    logic [AW-1:0] mul_wb_rd;
    logic [2:0]    inflight_cnt;

    mul_issue_ctrl #(.MUL_LATENCY(L), .WB_DELAY(WB), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_is_mul(issue_is_mul),
        .issue_writes_rd(issue_writes_rd), .issue_rd(issue_rd),
        .issue_uses_rs1(issue_uses_rs1), .issue_rs1(issue_rs1),
        .issue_uses_rs2(issue_uses_rs2), .issue_rs2(issue_rs2),
        .flush(flush), .stall(stall), .mul_accept(mul_accept),
        .mul_wb_valid(mul_wb_valid), .mul_wb_rd(mul_wb_rd),
        .inflight_cnt(inflight_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int acc; logic [AW-1:0] rd; } rec_t;
    typedef struct { int due; logic [AW-1:0] rd; } wb_t;

    rec_t live_q[$];
    wb_t  sb_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Writeback monitor: every mul_wb_valid pulse must match the oldest expected writeback.
    always @(negedge clk) begin
        if (mul_wb_valid) begin
            if (sb_q.size() == 0) begin
                chk("wb_spurious", 1, 0);
            end else begin
                wb_t e;
                e = sb_q.pop_front();
                chk("wb_cycle", cyc, e.due);
                chk("wb_rd", int'(mul_wb_rd), int'(e.rd));
            end
        end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            wb_t e;
            e = sb_q.pop_front();
            chk("wb_missing", 0, 1);
        end
    end

    // Present one instruction for one cycle, and check the issue outputs against the model.
    task automatic issue(input bit v, input bit m, input bit w, input int rd,
                         input bit u1, input int r1, input bit u2, input int r2,
                         input bit fl);
        bit   raw, waw, wbc, exp_stall, exp_acc;
        int   c, age;
        @(posedge clk);
        #1;
        issue_valid = v; issue_is_mul = m; issue_writes_rd = w; issue_rd = AW'(rd);
        issue_uses_rs1 = u1; issue_rs1 = AW'(r1);
        issue_uses_rs2 = u2; issue_rs2 = AW'(r2); flush = fl;
        #1;
        c = cyc;
        while (live_q.size() > 0 && live_q[0].acc + L < c) void'(live_q.pop_front());
        raw = 0; waw = 0; wbc = 0;
        foreach (live_q[i]) begin
            age = c - live_q[i].acc;
            if (live_q[i].rd != 0) begin
                if (u1 && live_q[i].rd == AW'(r1)) raw = 1;
                if (u2 && live_q[i].rd == AW'(r2)) raw = 1;
                if (!m && w && live_q[i].rd == AW'(rd)) waw = 1;
            end
            if (!m && w && age == L - WB) wbc = 1;
        end
        exp_stall = v && !fl && (raw || waw || wbc);
        exp_acc   = v && m && !exp_stall && !fl;
        chk("stall", int'(stall), int'(exp_stall));
        chk("mul_accept", int'(mul_accept), int'(exp_acc));
        chk("inflight_cnt", int'(inflight_cnt), live_q.size());
        chk("busy", int'(busy), int'(live_q.size() != 0));
        if (exp_acc) begin
            live_q.push_back('{acc: c, rd: AW'(rd)});
            sb_q.push_back('{due: c + L, rd: AW'(rd)});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Assert reset mid-cycle with a mul presented. The outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue_valid = 1; issue_is_mul = 1; issue_rd = 5'd9; flush = 0;
        issue_uses_rs1 = 0; issue_uses_rs2 = 0;
        live_q.delete();
        sb_q.delete();
        #1;
        chk("rst_stall", int'(stall), 0);
        chk("rst_accept", int'(mul_accept), 0);
        chk("rst_wb_valid", int'(mul_wb_valid), 0);
        chk("rst_wb_rd", int'(mul_wb_rd), 0);
        chk("rst_cnt", int'(inflight_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        issue_valid = 0; issue_is_mul = 0;
        rst = 1'b1;
    endtask

    initial begin
        do_reset();
        // independent muls to r1..r5
        for (int r = 1; r <= 5; r++) issue(1, 1, 1, r, 1, r + 10, 1, r + 20, 0);
        idle(7);
        // RAW on a mul result: the add must wait for the mul's writeback
        issue(1, 1, 1, 3, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) issue(1, 0, 1, 8, 1, 3, 0, 0, 0);
        idle(6);
        // writeback port collision with a mul at age 3
        issue(1, 1, 1, 4, 0, 0, 0, 0, 0);
        idle(2);
        issue(1, 0, 1, 7, 0, 0, 0, 0, 0);
        issue(1, 0, 1, 7, 0, 0, 0, 0, 0);
        idle(6);
        // mul to r0 is tracked but never a hazard
        issue(1, 1, 1, 0, 0, 0, 0, 0, 0);
        issue(1, 0, 1, 0, 1, 0, 1, 0, 0);
        idle(6);
        // reset drops the muls that are in flight
        for (int i = 0; i < 3; i++) issue(1, 1, 1, i + 1, 0, 0, 0, 0, 0);
        do_reset();
        idle(8);
        // a flushed mul is not accepted
        issue(1, 1, 1, 6, 0, 0, 0, 0, 0);
        issue(1, 1, 1, 7, 0, 0, 0, 0, 1);
        idle(6);
        // random traffic over a small register range, to force frequent hazards
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            issue($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                  $urandom_range(0, 9) == 0);
        end
        idle(L + 3);
        if (sb_q.size() != 0) chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
